// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, registered threshold flags, sticky
// overflow/underflow errors, synchronous flush and a standard or FWFT read port.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int LOG2DEPTH = 4,
    parameter int AF_THRESH = (2 ** LOG2DEPTH) - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     din,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [LOG2DEPTH:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam int DEPTH = 2 ** LOG2DEPTH;
    localparam int CW    = LOG2DEPTH + 1;

    localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]        AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]        AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [LOG2DEPTH-1:0] PTR_ONE = LOG2DEPTH'(1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG2DEPTH-1:0] wp;
    logic [LOG2DEPTH-1:0] rp;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_nxt;
    logic                 full_r;
    logic                 empty_r;
    logic                 af_r;
    logic                 ae_r;
    logic                 ovf_r;
    logic                 udf_r;

    logic rd_acc;
    logic wr_acc;
    logic wr_err;
    logic rd_err;

    // Acceptance is decided on registered flags only, so no request input
    // reaches a flag through combinational logic. Flush suppresses both.
    always_comb begin
        rd_acc = rd_en & ~empty_r & ~flush;
        wr_acc = wr_en & (~full_r | rd_acc) & ~flush;
        wr_err = wr_en & ~wr_acc & ~flush;
        rd_err = rd_en & ~rd_acc & ~flush;
    end

    always_comb begin
        count_nxt = count_r;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_nxt = count_r + CNT_ONE;
                2'b01:   count_nxt = count_r - CNT_ONE;
                default: count_nxt = count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
        end else begin
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (wr_acc) wp <= wp + PTR_ONE;
                if (rd_acc) rp <= rp + PTR_ONE;
            end
            count_r <= count_nxt;
            full_r  <= (count_nxt == DEPTH_C);
            empty_r <= (count_nxt == '0);
            af_r    <= (count_nxt >= AF_C);
            ae_r    <= (count_nxt <= AE_C);
        end
    end

    // Errors stay set until cleared; a fresh error in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= (ovf_r & ~clr_err) | wr_err;
            udf_r <= (udf_r & ~clr_err) | rd_err;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wp] <= din;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented directly; zero while empty so the port
            // reads 0 out of reset rather than stale storage.
            assign dout       = empty_r ? '0 : mem[rp];
            assign dout_valid = ~empty_r;
        end else begin : g_std
            logic [WIDTH-1:0] dout_r;
            logic             dout_valid_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_r       <= '0;
                    dout_valid_r <= 1'b0;
                end else begin
                    if (rd_acc) dout_r <= mem[rp];
                    dout_valid_r <= rd_acc;
                end
            end

            assign dout       = dout_r;
            assign dout_valid = dout_valid_r;
        end
    endgenerate

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read and an FWFT instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int W     = 8;
    localparam int L2D   = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] s_dout, f_dout;
    logic         s_dv, f_dv, s_full, f_full, s_empty, f_empty;
    logic         s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
    logic [L2D:0] s_count, f_count;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q[$];
    bit           m_ovf, m_udf, m_dv;
    logic [W-1:0] m_dout;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(W), .LOG2DEPTH(L2D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) dut_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err));

    sync_fifo_flags #(.WIDTH(W), .LOG2DEPTH(L2D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err));

    // Reference behaviour: a queue of stored words plus the sticky errors and
    // the registered read-port value for the standard instance.
    function automatic void model_step(bit w, bit r, bit f, bit c, logic [W-1:0] d);
        bit rok, wok;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_dv = 0; m_dout = '0;
            return;
        end
        if (c) begin
            m_ovf = 0; m_udf = 0;
        end
        if (f) begin
            q.delete();
            m_dv = 0;
            return;
        end
        rok = r && (q.size() > 0);
        wok = w && ((q.size() < DEPTH) || rok);
        if (w && !wok) m_ovf = 1;
        if (r && !rok) m_udf = 1;
        m_dv = rok;
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
    endfunction

    task automatic drive(input bit w, input bit r, input bit f, input bit c, input logic [W-1:0] d);
        wr_en = w; rd_en = r; flush = f; clr_err = c; din = d;
        @(posedge clk);
        model_step(w, r, f, c, d);
        #1;
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        drive(1, 1, 0, 0, 8'hFF);
        rst = 0;
        checks++; if (s_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", s_count); end
        checks++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", s_empty, s_full); end
        checks++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin failures++; $display("FAIL reset_almost got=%b%b exp=10", s_ae, s_af); end
        checks++; if (s_dout !== 8'h00 || s_dv !== 1'b0) begin failures++; $display("FAIL reset_dout got=%h/%b exp=00/0", s_dout, s_dv); end
        checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", s_ovf, s_udf); end
        checks++; if (f_dv !== 1'b0 || f_empty !== 1'b1) begin failures++; $display("FAIL reset_fwft got=%b/%b exp=0/1", f_dv, f_empty); end
    endtask

    task automatic test_fill();
        logic [W-1:0] data [4];
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, data[i]);
            checks++; if (s_count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, s_count, i + 1); end
            checks++; if (s_ae !== (i + 1 <= AE)) begin failures++; $display("FAIL fill_ae i=%0d got=%b", i, s_ae); end
            checks++; if (s_af !== (i + 1 >= AF)) begin failures++; $display("FAIL fill_af i=%0d got=%b", i, s_af); end
            checks++; if (s_full !== (i == 3)) begin failures++; $display("FAIL fill_full i=%0d got=%b", i, s_full); end
            checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL fill_ovf i=%0d got=%b exp=0", i, s_ovf); end
        end
    endtask

    task automatic test_overflow_underflow();
        logic [W-1:0] data [4];
        data = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive(1, 0, 0, 0, 8'h55);
        checks++; if (s_ovf !== 1'b1 || s_count !== 3'd4) begin failures++; $display("FAIL ovf_set got=%b/%0d exp=1/4", s_ovf, s_count); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 8'h00);
            checks++; if (s_dv !== 1'b1 || s_dout !== data[i]) begin failures++; $display("FAIL drain_word i=%0d got=%h/%b exp=%h/1", i, s_dout, s_dv, data[i]); end
            drive(0, 0, 0, 0, 8'h00);
            checks++; if (s_dv !== 1'b0 || s_dout !== data[i]) begin failures++; $display("FAIL drain_pulse i=%0d got=%h/%b exp=%h/0", i, s_dout, s_dv, data[i]); end
        end
        drive(0, 1, 0, 0, 8'h00);
        checks++; if (s_udf !== 1'b1 || s_empty !== 1'b1) begin failures++; $display("FAIL udf_set got=%b/%b exp=1/1", s_udf, s_empty); end
        drive(0, 0, 0, 1, 8'h00);
        checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin failures++; $display("FAIL clr_err got=%b%b exp=00", s_ovf, s_udf); end
        drive(1, 0, 0, 1, 8'h00);
        drive(0, 1, 0, 1, 8'h00);
        drive(0, 1, 0, 1, 8'h00);
        checks++; if (s_udf !== 1'b1) begin failures++; $display("FAIL clr_vs_new_err got=%b exp=1", s_udf); end
        drive(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 8'(8'hA0 + i));
        drive(1, 1, 0, 0, 8'h66);
        checks++; if (s_count !== 3'd4 || s_full !== 1'b1) begin failures++; $display("FAIL simul_full got=%0d/%b exp=4/1", s_count, s_full); end
        checks++; if (s_ovf !== 1'b0 || s_dout !== 8'hA0) begin failures++; $display("FAIL simul_full_rd got=%b/%h exp=0/a0", s_ovf, s_dout); end
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 8'h00);
        checks++; if (s_dout !== 8'h66) begin failures++; $display("FAIL simul_last got=%h exp=66", s_dout); end
        drive(1, 1, 0, 0, 8'h77);
        checks++; if (s_udf !== 1'b1 || s_count !== 3'd1 || s_ovf !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b/%0d/%b exp=1/1/0", s_udf, s_count, s_ovf); end
        drive(0, 1, 0, 0, 8'h00);
        checks++; if (s_dout !== 8'h77) begin failures++; $display("FAIL simul_empty_rd got=%h exp=77", s_dout); end
        drive(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 8'(i));
            checks++; if (s_count !== 3'd1) begin failures++; $display("FAIL wrap_count i=%0d got=%0d exp=1", i, s_count); end
            drive(0, 1, 0, 0, 8'h00);
            checks++; if (s_dout !== 8'(i) || s_dv !== 1'b1) begin failures++; $display("FAIL wrap_order i=%0d got=%h/%b exp=%h/1", i, s_dout, s_dv, 8'(i)); end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 8'(8'hC0 + i));
        drive(1, 1, 1, 0, 8'h99);
        checks++; if (s_count !== 3'd0 || s_empty !== 1'b1 || s_full !== 1'b0) begin failures++; $display("FAIL flush_state got=%0d/%b/%b exp=0/1/0", s_count, s_empty, s_full); end
        checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0 || s_dv !== 1'b0) begin failures++; $display("FAIL flush_err got=%b%b/%b exp=00/0", s_ovf, s_udf, s_dv); end
        checks++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin failures++; $display("FAIL flush_almost got=%b%b exp=10", s_ae, s_af); end
        drive(1, 0, 0, 0, 8'hAA);
        drive(0, 1, 0, 0, 8'h00);
        checks++; if (s_dout !== 8'hAA || s_dv !== 1'b1) begin failures++; $display("FAIL flush_after got=%h/%b exp=aa/1", s_dout, s_dv); end
    endtask

    task automatic test_fwft();
        drive(1, 0, 0, 0, 8'h5A);
        checks++; if (f_dv !== 1'b1 || f_dout !== 8'h5A) begin failures++; $display("FAIL fwft_show got=%h/%b exp=5a/1", f_dout, f_dv); end
        drive(0, 0, 0, 0, 8'h00);
        checks++; if (f_dv !== 1'b1 || f_dout !== 8'h5A) begin failures++; $display("FAIL fwft_hold got=%h/%b exp=5a/1", f_dout, f_dv); end
        drive(0, 1, 0, 0, 8'h00);
        checks++; if (f_dv !== 1'b0 || f_empty !== 1'b1) begin failures++; $display("FAIL fwft_pop got=%b/%b exp=0/1", f_dv, f_empty); end
    endtask

    task automatic test_random();
        int n;
        bit w, r, f, c;
        logic [W-1:0] d;
        for (int cyc = 0; cyc < 600; cyc++) begin
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < 5);
            d = 8'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            drive(w, r, f, c, d);
            rst = 0;
            n = q.size();
            checks++; if (s_count !== 3'(n) || f_count !== 3'(n)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d/%0d exp=%0d", cyc, s_count, f_count, n); end
            checks++; if (s_full !== (n == DEPTH) || s_empty !== (n == 0) || f_full !== (n == DEPTH) || f_empty !== (n == 0)) begin failures++; $display("FAIL rand_full_empty cyc=%0d got=%b%b%b%b n=%0d", cyc, s_full, s_empty, f_full, f_empty, n); end
            checks++; if (s_af !== (n >= AF) || s_ae !== (n <= AE) || f_af !== (n >= AF) || f_ae !== (n <= AE)) begin failures++; $display("FAIL rand_almost cyc=%0d got=%b%b%b%b n=%0d", cyc, s_af, s_ae, f_af, f_ae, n); end
            checks++; if (s_ovf !== m_ovf || s_udf !== m_udf || f_ovf !== m_ovf || f_udf !== m_udf) begin failures++; $display("FAIL rand_err cyc=%0d got=%b%b/%b%b exp=%b%b", cyc, s_ovf, s_udf, f_ovf, f_udf, m_ovf, m_udf); end
            checks++; if (s_dv !== m_dv || s_dout !== m_dout) begin failures++; $display("FAIL rand_std_dout cyc=%0d got=%h/%b exp=%h/%b", cyc, s_dout, s_dv, m_dout, m_dv); end
            checks++; if (f_dv !== (n > 0) || (n > 0 && f_dout !== q[0])) begin failures++; $display("FAIL rand_fwft_dout cyc=%0d got=%h/%b exp_valid=%b", cyc, f_dout, f_dv, n > 0); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        test_flush();
        test_fwft();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO that succeeds the team's basic synchronous FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It also adds a synchronous flush and a selectable read mode: standard registered read, or first-word fall-through (FWFT). It is used as the generic buffer between datapath stages in one clock domain.

Parameters:
WIDTH, 8, data word width in bits
LOG2DEPTH, 4, log2 of storage depth; DEPTH = 2**LOG2DEPTH, all DEPTH entries usable
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous clear of contents/pointers/count
wr_en  input  1  write request
din  input  WIDTH  write data
rd_en  input  1  read request (in FWFT: pop head)
dout  output  WIDTH  read data
dout_valid  output  1  dout holds a valid word (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  LOG2DEPTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write request was rejected
underflow  output  1  sticky: read request was rejected
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=1 at edge): wp=rp=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory contents are not reset. rst overrides flush, wr_en, rd_en and clr_err.
- Acceptance rules, evaluated on pre-edge state:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
  - A read while empty is never satisfied by a same-cycle write.
- On wr_acc: mem[wp] <= din; wp increments modulo DEPTH (natural wrap).
- On rd_acc: rp increments modulo DEPTH.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- Flags: full, empty, almost_full and almost_empty are registered. They reflect the post-edge count, with no combinational path from wr_en/rd_en to any flag.
- Errors:
  - overflow <= 1 when wr_en & ~wr_acc.
  - underflow <= 1 when rd_en & ~rd_acc.
  - Both hold until clr_err=1 or rst.
  - If clr_err and a new error occur in the same cycle, the flag ends up set.
- Flush (flush=1, rst=0):
  - Next state: wp=rp=0, count=0, empty=1, full=0, almost flags recomputed for count=0, dout_valid=0.
  - wr_en and rd_en are ignored that cycle and raise no error.
  - dout value and error flags are retained.
- Standard mode (FWFT=0):
  - On rd_acc: dout <= mem[rp] at the edge, and dout_valid=1 for exactly the following cycle.
  - Otherwise dout holds its last value and dout_valid=0.
  - Read latency is 1 cycle from accepted rd_en.
- FWFT mode (FWFT=1):
  - dout = mem[rp] combinationally and dout_valid = ~empty.
  - rd_en with dout_valid consumes the head.
  - A word written into an empty FIFO appears on dout the cycle after the write edge.
- Wrap-around: pointers wrap silently. count alone distinguishes full from empty.

Test Plan:
- Reset, then fill: LOG2DEPTH=2, AF_THRESH=3, AE_THRESH=1; write 0x11,0x22,0x33,0x44 -> count 1,2,3,4. almost_empty clears after the 2nd write, almost_full sets after the 3rd, full=1 after the 4th, overflow=0.
- Overflow/underflow: write 0x55 when full -> rejected, overflow=1, count stays 4. Drain 4 words -> dout 0x11..0x44, each with a 1-cycle dout_valid pulse. Extra rd_en -> underflow=1. clr_err -> both 0.
- Simultaneous rd/wr:
  - at full -> both accepted, count stays 4, full stays 1, no overflow;
  - at empty -> only the write is accepted, underflow=1, count=1.
- Wrap-around: 10 write/read pairs with data 0..9 through the depth-4 FIFO -> read order 0..9 exact, count never above 1.
- Flush mid-traffic: with 3 words stored, assert flush together with wr_en=1 and rd_en=1 -> count=0, empty=1, no error flags. The next write of 0xAA reads back 0xAA.
- FWFT=1: write 0x5A into the empty FIFO -> dout=0x5A and dout_valid=1 the next cycle without rd_en. rd_en -> dout_valid=0 and empty=1 the following cycle.
